// File: rtl/mc_controller.sv
// mc_controller: multi-cycle processor control FSM.
//
// Sequences fetch, decode, memory access, ALU execute/write-back and branch
// for a multi-cycle datapath. A wait counter watches memory handshakes and
// sends the FSM to a terminal FAULT state when memory stalls for too long.
//
// Optional feature: define MC_CTRL_LINK_EN to add the LINK state
// (branch-with-link writes the current PC to r14 before branching).
// With the macro undefined, op=10 always branches and link_sel is tied 0.
//
// Ports
//   clk, reset          : single rising-edge clock, synchronous active-low reset
//   op, funct, rd       : decoded instruction class, funct field, destination reg
//   cond_ok             : instruction condition passed
//   mem_ready / mem_req : memory handshake
//   ir_write, pc_write, reg_w, mem_w, alu_op, flag_w_en, link_sel, fault
//                       : datapath strobes
//   adr_src, alu_src_a, alu_src_b, result_src : datapath mux selects
//   state_o             : current state encoding (debug only)
//
// state    | meaning
// ---------+------------------------------------------------------------
// FETCH    | read instruction at PC, PC+4 written on mem_ready
// DECODE   | pick the instruction path, PC+4 available on ALU
// MEMADDR  | compute load/store address
// MEMREAD  | load data read, waits on mem_ready
// MEMWRITE | store data write, waits on mem_ready
// MEMWB    | write loaded data to rd (PC when rd=15)
// EXECR    | ALU op with register operand
// EXECI    | ALU op with immediate operand
// ALUWB    | ALU result write-back and flag update
// BRANCH   | PC <- branch target
// LINK     | r14 <- PC, only with MC_CTRL_LINK_EN
// FAULT    | illegal op or memory timeout, held until reset
module mc_controller #(
    parameter int unsigned MAX_WAIT = 15,  // 0 disables the memory timeout
    parameter int unsigned WAIT_W   = 4    // must hold MAX_WAIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic       cond_ok,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_w,
    output logic       mem_w,
    output logic       alu_op,
    output logic       flag_w_en,
    output logic       link_sel,
    output logic       fault,
    output logic       adr_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADDR  = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWRITE = 4'd4,
        ST_MEMWB    = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9,
`ifdef MC_CTRL_LINK_EN
        ST_LINK     = 4'd10,
`endif
        ST_FAULT    = 4'd15
    } state_t;

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              wb_en;
    logic              timeout_hit;

    // funct[2:1] carry no control information.
    logic unused_funct;
    assign unused_funct = ^funct[2:1];

    assign state_o = state_q;

    // Outputs are a pure decode of the state register (plus the few inputs
    // the handshake and write-back rules need), so they are not re-registered:
    // ir_write/pc_write in FETCH must follow mem_ready in the same cycle.
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_w       = 1'b0;
        mem_w       = 1'b0;
        alu_op      = 1'b0;
        flag_w_en   = 1'b0;
        link_sel    = 1'b0;
        fault       = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        wb_en       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req    = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (!cond_ok) begin
                    state_d = ST_FETCH;
                end else begin
                    case (op)
                        2'b01:   state_d = ST_MEMADDR;
                        2'b00:   state_d = funct[5] ? ST_EXECI : ST_EXECR;
`ifdef MC_CTRL_LINK_EN
                        2'b10:   state_d = funct[4] ? ST_LINK : ST_BRANCH;
`else
                        2'b10:   state_d = ST_BRANCH;
`endif
                        default: state_d = ST_FAULT;
                    endcase
                end
            end
            ST_MEMADDR: begin
                alu_src_b = 2'b01;
                state_d   = funct[0] ? ST_MEMREAD : ST_MEMWRITE;
            end
            ST_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = ST_MEMWB;
            end
            ST_MEMWRITE: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                mem_w   = 1'b1;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
                pc_write   = (rd == 4'd15);
                state_d    = ST_FETCH;
            end
            ST_EXECR: begin
                alu_op  = 1'b1;
                state_d = ST_ALUWB;
            end
            ST_EXECI: begin
                alu_op    = 1'b1;
                alu_src_b = 2'b01;
                state_d   = ST_ALUWB;
            end
            ST_ALUWB: begin
                alu_op    = 1'b1;
                flag_w_en = funct[0];
                // compare/test class only updates flags
                wb_en     = (funct[4:3] != 2'b10);
                reg_w     = wb_en;
                pc_write  = wb_en & (rd == 4'd15);
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write   = 1'b1;
                state_d    = ST_FETCH;
            end
`ifdef MC_CTRL_LINK_EN
            ST_LINK: begin
                reg_w      = 1'b1;
                link_sel   = 1'b1;
                result_src = 2'b11;
                state_d    = ST_BRANCH;
            end
`endif
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase

        // mem_req marks exactly the states that wait on memory. A ready in
        // the limit cycle still completes normally.
        timeout_hit = (MAX_WAIT != 0) && mem_req && !mem_ready
                      && (wait_cnt_q == WAIT_LIMIT);
        if (timeout_hit) state_d = ST_FAULT;

        if (state_d != state_q)
            wait_cnt_d = '0;
        else if (mem_req && !mem_ready && (wait_cnt_q < WAIT_LIMIT))
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        else
            wait_cnt_d = wait_cnt_q;

        // Keep the datapath from committing anything while held in reset.
        if (!reset) begin
            mem_w    = 1'b0;
            reg_w    = 1'b0;
            pc_write = 1'b0;
            ir_write = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADDR = 2, S_MEMREAD = 3,
                   S_MEMWRITE = 4, S_MEMWB = 5, S_EXECR = 6, S_EXECI = 7,
                   S_ALUWB = 8, S_BRANCH = 9, S_LINK = 10, S_FAULT = 15;
    localparam int MAXW = 15;
`ifdef MC_CTRL_LINK_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       cond_ok;
    logic       mem_ready;

    logic       a_mem_req, a_ir_write, a_pc_write, a_reg_w, a_mem_w, a_alu_op;
    logic       a_flag_w_en, a_link_sel, a_fault, a_adr_src, a_alu_src_a;
    logic [1:0] a_alu_src_b, a_result_src;
    logic [3:0] a_state;

    logic       unused_n_mem_req, unused_n_ir_write, unused_n_pc_write, unused_n_reg_w;
    logic       unused_n_mem_w, unused_n_alu_op, unused_n_flag_w_en, unused_n_link_sel;
    logic       unused_n_fault, unused_n_adr_src, unused_n_alu_src_a;
    logic [1:0] unused_n_alu_src_b, unused_n_result_src;
    logic [3:0] n_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_controller #(.MAX_WAIT(MAXW), .WAIT_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
        .cond_ok(cond_ok), .mem_ready(mem_ready), .mem_req(a_mem_req),
        .ir_write(a_ir_write), .pc_write(a_pc_write), .reg_w(a_reg_w),
        .mem_w(a_mem_w), .alu_op(a_alu_op), .flag_w_en(a_flag_w_en),
        .link_sel(a_link_sel), .fault(a_fault), .adr_src(a_adr_src),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b),
        .result_src(a_result_src), .state_o(a_state)
    );

    // Same stimulus, timeout disabled.
    mc_controller #(.MAX_WAIT(0), .WAIT_W(4)) dut_nowait (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
        .cond_ok(cond_ok), .mem_ready(mem_ready), .mem_req(unused_n_mem_req),
        .ir_write(unused_n_ir_write), .pc_write(unused_n_pc_write),
        .reg_w(unused_n_reg_w), .mem_w(unused_n_mem_w), .alu_op(unused_n_alu_op),
        .flag_w_en(unused_n_flag_w_en), .link_sel(unused_n_link_sel),
        .fault(unused_n_fault), .adr_src(unused_n_adr_src),
        .alu_src_a(unused_n_alu_src_a), .alu_src_b(unused_n_alu_src_b),
        .result_src(unused_n_result_src), .state_o(n_state)
    );

    typedef struct {
        bit         rst;
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] rd;
        bit         cond;
        bit         mr;
        logic [11:0] exp;  // {state, mem_req, ir_write, pc_write, reg_w, mem_w, flag_w_en, result_src}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, logic [1:0] o, logic [5:0] f, logic [3:0] d,
                                bit c, bit m, logic [3:0] st, logic [5:0] strobes,
                                logic [1:0] rs);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.rd = d; v.cond = c; v.mr = m;
        v.exp = {st, strobes, rs};
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(bit r, logic [1:0] o, logic [5:0] f, logic [3:0] d, bit c, bit m);
        reset = r; op = o; funct = f; rd = d; cond_ok = c; mem_ready = m;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int m_st;
    int m_stall;  // consecutive stalled cycles spent in the current waiting state

    function automatic logic [18:0] exp_vec(int st, bit mr, logic [3:0] d, logic [5:0] f, bit r);
        bit mreq, irw, pcw, rw, mw, aop, fw, ls, flt, adr, sa;
        logic [1:0] sb, rs;
        mreq = 0; irw = 0; pcw = 0; rw = 0; mw = 0; aop = 0; fw = 0; ls = 0;
        flt = 0; adr = 0; sa = 0; sb = 2'd0; rs = 2'd0;
        case (st)
            S_FETCH:    begin mreq = 1; sa = 1; sb = 2'd2; rs = 2'd2; irw = mr; pcw = mr; end
            S_DECODE:   begin sa = 1; sb = 2'd2; rs = 2'd2; end
            S_MEMADDR:  sb = 2'd1;
            S_MEMREAD:  begin mreq = 1; adr = 1; end
            S_MEMWRITE: begin mreq = 1; adr = 1; mw = 1; end
            S_MEMWB:    begin rs = 2'd1; rw = 1; pcw = (d == 4'd15); end
            S_EXECR:    aop = 1;
            S_EXECI:    begin aop = 1; sb = 2'd1; end
            S_ALUWB:    begin aop = 1; fw = f[0]; rw = (f[4:3] != 2'b10); pcw = rw && (d == 4'd15); end
            S_BRANCH:   begin sb = 2'd1; rs = 2'd2; pcw = 1; end
            S_LINK:     begin rw = 1; ls = 1; rs = 2'd3; end
            S_FAULT:    flt = 1;
            default:    flt = 0;
        endcase
        if (!r) begin irw = 0; pcw = 0; rw = 0; mw = 0; end
        return {mreq, irw, pcw, rw, mw, aop, fw, ls, flt, adr, sa, sb, rs, 4'(st)};
    endfunction

    task automatic model_step(bit r, logic [1:0] o, logic [5:0] f, bit c, bit mr);
        int nxt;
        bit waits;
        if (!r) begin
            m_st = S_FETCH;
            m_stall = 0;
            return;
        end
        waits = (m_st == S_FETCH) || (m_st == S_MEMREAD) || (m_st == S_MEMWRITE);
        nxt = m_st;
        case (m_st)
            S_FETCH:    if (mr) nxt = S_DECODE;
            S_DECODE: begin
                if (!c)            nxt = S_FETCH;
                else if (o == 2'd1) nxt = S_MEMADDR;
                else if (o == 2'd0) nxt = f[5] ? S_EXECI : S_EXECR;
                else if (o == 2'd2) nxt = (LINK_EN && f[4]) ? S_LINK : S_BRANCH;
                else               nxt = S_FAULT;
            end
            S_MEMADDR:  nxt = f[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mr) nxt = S_MEMWB;
            S_MEMWRITE: if (mr) nxt = S_FETCH;
            S_EXECR, S_EXECI: nxt = S_ALUWB;
            S_LINK:     nxt = S_BRANCH;
            S_FAULT:    nxt = S_FAULT;
            default:    nxt = S_FETCH;
        endcase
        if (waits && !mr && m_stall == MAXW) nxt = S_FAULT;
        if (nxt != m_st) m_stall = 0;
        else if (waits && !mr && m_stall < MAXW) m_stall++;
        m_st = nxt;
    endtask

    initial begin
        logic [11:0] got;
        logic [1:0]  r_op;
        logic [5:0]  r_f;
        logic [3:0]  r_rd;
        bit          r_c, r_m, r_rst;
        int          stall_left, fault_cycles;

        // ---------------- table-driven vectors ----------------
        tbl.push_back(mk(0, 2'd0, 6'b101001, 4'd3, 1, 1, 4'd0, 6'b100000, 2'd2));
        tbl.push_back(mk(1, 2'd0, 6'b101001, 4'd3, 1, 1, 4'd0, 6'b111000, 2'd2));
        tbl.push_back(mk(1, 2'd0, 6'b101001, 4'd3, 1, 1, 4'd1, 6'b000000, 2'd2));
        tbl.push_back(mk(1, 2'd0, 6'b101001, 4'd3, 1, 1, 4'd7, 6'b000000, 2'd0));
        tbl.push_back(mk(1, 2'd0, 6'b101001, 4'd3, 1, 1, 4'd8, 6'b000101, 2'd0));
        tbl.push_back(mk(1, 2'd0, 6'b010101, 4'd15, 1, 1, 4'd0, 6'b111000, 2'd2));
        tbl.push_back(mk(1, 2'd0, 6'b010101, 4'd15, 1, 1, 4'd1, 6'b000000, 2'd2));
        tbl.push_back(mk(1, 2'd0, 6'b010101, 4'd15, 1, 1, 4'd6, 6'b000000, 2'd0));
        tbl.push_back(mk(1, 2'd0, 6'b010101, 4'd15, 1, 1, 4'd8, 6'b000001, 2'd0));
        tbl.push_back(mk(1, 2'd0, 6'b000000, 4'd5, 0, 1, 4'd0, 6'b111000, 2'd2));
        tbl.push_back(mk(1, 2'd0, 6'b000000, 4'd5, 0, 1, 4'd1, 6'b000000, 2'd2));
        tbl.push_back(mk(1, 2'd1, 6'b000001, 4'd15, 1, 1, 4'd0, 6'b111000, 2'd2));
        tbl.push_back(mk(1, 2'd1, 6'b000001, 4'd15, 1, 1, 4'd1, 6'b000000, 2'd2));
        tbl.push_back(mk(1, 2'd1, 6'b000001, 4'd15, 1, 1, 4'd2, 6'b000000, 2'd0));
        tbl.push_back(mk(1, 2'd1, 6'b000001, 4'd15, 1, 0, 4'd3, 6'b100000, 2'd0));
        tbl.push_back(mk(1, 2'd1, 6'b000001, 4'd15, 1, 0, 4'd3, 6'b100000, 2'd0));
        tbl.push_back(mk(1, 2'd1, 6'b000001, 4'd15, 1, 0, 4'd3, 6'b100000, 2'd0));
        tbl.push_back(mk(1, 2'd1, 6'b000001, 4'd15, 1, 1, 4'd3, 6'b100000, 2'd0));
        tbl.push_back(mk(1, 2'd1, 6'b000001, 4'd15, 1, 1, 4'd5, 6'b001100, 2'd1));
        tbl.push_back(mk(1, 2'd1, 6'b000001, 4'd15, 1, 0, 4'd0, 6'b100000, 2'd2));

        apply(0, 2'd0, 6'd0, 4'd0, 1, 0);
        cyc();
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].rst, tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].cond, tbl[i].mr);
            got = {a_state, a_mem_req, a_ir_write, a_pc_write, a_reg_w, a_mem_w,
                   a_flag_w_en, a_result_src};
            check($sformatf("table_row%0d", i), 32'(got), 32'(tbl[i].exp));
            cyc();
        end

        // ---------------- memory timeout in FETCH ----------------
        apply(0, 2'd0, 6'd0, 4'd0, 1, 0);
        cyc();
        for (int k = 1; k <= 16; k++) begin
            apply(1, 2'd0, 6'd0, 4'd0, 1, 0);
            if (k == 1 || k == 16) check($sformatf("timeout_fetch_cycle%0d", k), 32'(a_state), S_FETCH);
            cyc();
        end
        check("timeout_state", 32'(a_state), S_FAULT);
        check("timeout_fault", 32'(a_fault), 1);
        check("timeout_mem_req", 32'(a_mem_req), 0);
        for (int k = 0; k < 30; k++) cyc();
        check("nowait_holds_fetch", 32'(n_state), S_FETCH);
        apply(1, 2'd0, 6'd0, 4'd0, 1, 1);
        cyc();
        check("fault_terminal", 32'(a_state), S_FAULT);
        apply(0, 2'd0, 6'd0, 4'd0, 1, 0);
        cyc();
        apply(1, 2'd0, 6'd0, 4'd0, 1, 0);
        check("fault_reset_state", 32'(a_state), S_FETCH);
        check("fault_reset_flag", 32'(a_fault), 0);

        // ---------------- ready on the limit cycle ----------------
        apply(0, 2'd0, 6'd0, 4'd0, 1, 0);
        cyc();
        for (int k = 1; k <= 15; k++) begin
            apply(1, 2'd0, 6'd0, 4'd0, 1, 0);
            cyc();
        end
        apply(1, 2'd0, 6'd0, 4'd0, 1, 1);
        check("limit_ready_state", 32'(a_state), S_FETCH);
        check("limit_ready_ir_write", 32'(a_ir_write), 1);
        cyc();
        check("limit_ready_decode", 32'(a_state), S_DECODE);

        // ---------------- reset in the middle of a store wait ----------------
        apply(0, 2'd0, 6'd0, 4'd0, 1, 0);
        cyc();
        apply(1, 2'd1, 6'b000000, 4'd2, 1, 1);
        cyc(); cyc(); cyc();
        apply(1, 2'd1, 6'b000000, 4'd2, 1, 0);
        check("store_state", 32'(a_state), S_MEMWRITE);
        check("store_strobes", 32'({a_mem_req, a_adr_src, a_mem_w}), 32'h7);
        for (int k = 0; k < 10; k++) cyc();
        apply(0, 2'd1, 6'b000000, 4'd2, 1, 0);
        check("store_reset_masks_mem_w", 32'(a_mem_w), 0);
        cyc();
        for (int k = 1; k <= 16; k++) begin
            apply(1, 2'd1, 6'b000000, 4'd2, 1, 0);
            if (k == 16) check("counter_cleared_by_reset", 32'(a_state), S_FETCH);
            cyc();
        end
        check("counter_refault", 32'(a_state), S_FAULT);

        // ---------------- branch / link ----------------
        apply(0, 2'd0, 6'd0, 4'd0, 1, 0);
        cyc();
        apply(1, 2'd2, 6'b110000, 4'd0, 1, 1);
        cyc();
        check("br_decode", 32'(a_state), S_DECODE);
        cyc();
        if (LINK_EN) begin
            check("link_state", 32'(a_state), S_LINK);
            check("link_strobes", 32'({a_reg_w, a_link_sel, a_result_src}), 32'b1111);
            cyc();
        end
        check("br_state", 32'(a_state), S_BRANCH);
        check("br_strobes", 32'({a_pc_write, a_link_sel, a_reg_w}), 32'b100);
        cyc();
        check("br_back_fetch", 32'(a_state), S_FETCH);

        // ---------------- illegal op ----------------
        apply(1, 2'd3, 6'd0, 4'd0, 1, 1);
        cyc(); cyc();
        check("illegal_op_fault", 32'(a_state), S_FAULT);

        // ---------------- randomized against the model ----------------
        apply(0, 2'd0, 6'd0, 4'd0, 1, 0);
        model_step(0, 2'd0, 6'd0, 1, 0);
        cyc();
        stall_left = 0;
        fault_cycles = 0;
        for (int n = 0; n < 4000; n++) begin
            r_op  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_f   = 6'($urandom);
            r_rd  = 4'($urandom);
            r_c   = ($urandom_range(0, 7) != 0);
            if (stall_left == 0 && $urandom_range(0, 149) == 0) stall_left = $urandom_range(10, 20);
            if (stall_left > 0) begin
                r_m = 0;
                stall_left--;
            end else begin
                r_m = ($urandom_range(0, 3) != 0);
            end
            fault_cycles = (m_st == S_FAULT) ? fault_cycles + 1 : 0;
            r_rst = !((fault_cycles > 3) || ($urandom_range(0, 299) == 0));
            apply(r_rst, r_op, r_f, r_rd, r_c, r_m);
            check($sformatf("random_cycle%0d", n),
                  32'({a_mem_req, a_ir_write, a_pc_write, a_reg_w, a_mem_w, a_alu_op,
                       a_flag_w_en, a_link_sel, a_fault, a_adr_src, a_alu_src_a,
                       a_alu_src_b, a_result_src, a_state}),
                  32'(exp_vec(m_st, r_m, r_rd, r_f, r_rst)));
            model_step(r_rst, r_op, r_f, r_c, r_m);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
